mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the processor's single-ported, fixed-latency unified memory between two requesters: instruction fetch (IF) and the MEM stage (loads and stores, as decoded by the control unit's memRead/memWrite).
- Serialises accesses and drives the memory-side strobes.
- Returns per-requester done, data and stall signals so the pipeline can freeze the affected stage.
- Sits between the fetch/memory stages and the memory model.

Parameters:
LATENCY, 4, cycles from accept edge to completion cycle (legal range ≥1)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
if_req  input  1  fetch read request, held until if_done or flush
if_addr  input  ADDR_W  fetch address (PC)
if_flush  input  1  kill current/pending fetch (taken branch/jump)
mem_rd  input  1  MEM-stage load request
mem_wr  input  1  MEM-stage store request
mem_addr  input  ADDR_W  load/store address
mem_wdata  input  DATA_W  store data
m_rdata  input  DATA_W  memory read data, valid in completion cycle
if_done  output  1  fetch complete this cycle
if_rdata  output  DATA_W  instruction word
if_stall  output  1  freeze fetch stage
mem_done  output  1  MEM access complete this cycle
mem_rdata  output  DATA_W  load data
mem_stall  output  1  freeze MEM stage and older stages
m_rd  output  1  memory read strobe, one-cycle pulse
m_wr  output  1  memory write strobe, one-cycle pulse
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
err  output  1  illegal request (mem_rd & mem_wr together)

Behaviour:
- States: IDLE, BUSY_IF, BUSY_MEM. Down-counter cnt, width clog2(LATENCY+1). kill flag, 1 bit.
- Accept (only in IDLE, at a rising edge):
  - MEM has priority over IF (older instruction).
  - mem_rd^mem_wr → BUSY_MEM, cnt=LATENCY.
  - Otherwise if_req & ~if_flush → BUSY_IF, cnt=LATENCY, kill=0.
- Memory strobes:
  - m_rd/m_wr/m_addr/m_wdata are registered.
  - They are asserted exactly in the first BUSY cycle after the accept edge, then m_rd/m_wr return to 0.
  - m_addr/m_wdata hold their last value.
  - m_wdata is 0 for reads.
- Countdown and completion:
  - Each BUSY edge decrements cnt.
  - The completion cycle is the one where cnt==1.
  - In that cycle: done pulses for the owner, rdata = m_rdata (combinational), and the next edge returns to IDLE.
  - Completion is LATENCY cycles after accept (LATENCY=1: strobe and completion share the same cycle).
- No accept on the edge that ends a completion cycle. At least one IDLE cycle (bubble) is guaranteed between accesses, so a still-high request is never double-served.
- Store completion: mem_done=1, mem_rdata=0.
- if_rdata/mem_rdata are 0 whenever the corresponding done=0.
- Stall outputs:
  - if_stall = if_req & ~if_done & ~if_flush.
  - mem_stall = (mem_rd|mem_wr) & ~mem_done.
- Flush:
  - if_flush in any BUSY_IF cycle (including completion) sets kill. Completion then suppresses if_done/if_rdata.
  - The arbiter still waits for cnt to expire; memory is not aborted.
  - if_flush in IDLE blocks IF accept that cycle.
  - Flush has no effect on BUSY_MEM.
- Illegal request: mem_rd&mem_wr in IDLE → not accepted, no strobes. err=1 and mem_done=1 in the following cycle, stays IDLE. err is a registered one-cycle pulse.
- Request dropped mid-BUSY by its owner: ignored; the access completes normally.
- Reset (async, rst_n=0):
  - Immediately: state IDLE, cnt=0, kill=0.
  - All registered outputs (m_rd, m_wr, m_addr, m_wdata, err) = 0.
  - done/rdata outputs = 0.
  - Any in-flight access is discarded with no done after release.

Test Plan:
- LATENCY=4, IDLE, if_req=1 if_addr=0x0010, m_rdata=0xABCD → m_rd=1 with m_addr=0x0010 for one cycle; if_stall high 3 cycles; if_done=1 with if_rdata=0xABCD 4 cycles after accept; next accept one cycle later.
- Simultaneous if_req (0x0010) and mem_rd (0x0200) → m_addr=0x0200 first, mem_done after 4 cycles; if_stall high throughout; IF strobe one bubble cycle later; if_done 9 cycles after first accept.
- mem_wr addr=0x0040 wdata=0x1234 → m_wr=1, m_wdata=0x1234 one cycle; mem_done=1 and mem_rdata=0 at completion; m_rd never asserted.
- Fetch accepted, if_flush pulsed in second BUSY cycle → no if_done; arbiter busy until cycle 4; new if_req 0x0020 accepted after the bubble and completes normally.
- mem_rd=mem_wr=1 in IDLE → next cycle err=1 and mem_done=1; m_rd=m_wr=0 throughout; state stays IDLE.
- rst_n low during the second BUSY_MEM cycle → all outputs 0 immediately; after release, IDLE with no mem_done; a fresh mem_rd is served with full LATENCY.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester- and memory-side signals of the unified-memory arbiter.
// slave: the arbiter itself; master: the fetch/MEM stages plus the memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              m_rd;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              err;

  modport slave (
    input  if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata,
    output if_done, if_rdata, if_stall, mem_done, mem_rdata, mem_stall,
           m_rd, m_wr, m_addr, m_wdata, err
  );

  modport master (
    output if_req, if_addr, if_flush, mem_rd, mem_wr, mem_addr, mem_wdata, m_rdata,
    input  if_done, if_rdata, if_stall, mem_done, mem_rdata, mem_stall,
           m_rd, m_wr, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and MEM-stage accesses onto a single-ported,
// fixed-latency memory; MEM wins ties, and every access is followed by an idle bubble.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              op_wr_q, op_wr_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              err_q, err_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      op_wr_q   <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      op_wr_q   <= op_wr_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    op_wr_d   = op_wr_q;
    m_rd_d    = 1'b0;
    m_wr_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A simultaneous load+store is flagged and never reaches memory.
        err_d = bus.mem_rd & bus.mem_wr;
        if (bus.mem_rd ^ bus.mem_wr) begin
          state_d   = BUSY_MEM;
          cnt_d     = LAT_C;
          op_wr_d   = bus.mem_wr;
          m_rd_d    = bus.mem_rd;
          m_wr_d    = bus.mem_wr;
          m_addr_d  = bus.mem_addr;
          m_wdata_d = bus.mem_wr ? bus.mem_wdata : '0;
        end else if (bus.if_req && !bus.if_flush) begin
          state_d   = BUSY_IF;
          cnt_d     = LAT_C;
          kill_d    = 1'b0;
          op_wr_d   = 1'b0;
          m_rd_d    = 1'b1;
          m_addr_d  = bus.if_addr;
          m_wdata_d = '0;
        end
      end
      BUSY_IF: begin
        cnt_d = cnt_q - ONE_C;
        if (bus.if_flush) kill_d = 1'b1;
        if (cnt_q == ONE_C) state_d = IDLE;
      end
      BUSY_MEM: begin
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  logic              if_done_c, mem_done_c;
  logic [DATA_W-1:0] if_rdata_c, mem_rdata_c;

  always_comb begin
    // A flush in the completion cycle itself also hides the returning word.
    if_done_c   = (state_q == BUSY_IF) && (cnt_q == ONE_C) && !kill_q && !bus.if_flush;
    mem_done_c  = ((state_q == BUSY_MEM) && (cnt_q == ONE_C)) || err_q;
    if_rdata_c  = if_done_c ? bus.m_rdata : '0;
    mem_rdata_c = '0;
    if ((state_q == BUSY_MEM) && (cnt_q == ONE_C) && !op_wr_q) mem_rdata_c = bus.m_rdata;
  end

  assign bus.if_done   = if_done_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.if_stall  = bus.if_req & ~if_done_c & ~bus.if_flush;
  assign bus.mem_done  = mem_done_c;
  assign bus.mem_rdata = mem_rdata_c;
  assign bus.mem_stall = (bus.mem_rd | bus.mem_wr) & ~mem_done_c;
  assign bus.m_rd      = m_rd_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter at LATENCY=4; inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.LATENCY(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic nc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.m_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    nc(2);
    total++; if ({bus.m_rd, bus.m_wr, bus.err, bus.if_done, bus.mem_done} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {bus.m_rd, bus.m_wr, bus.err, bus.if_done, bus.mem_done}); end
    total++; if ({bus.m_addr, bus.m_wdata} !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=00000000", {bus.m_addr, bus.m_wdata}); end
    rst_n = 1;
    nc(2);
  endtask

  task automatic test_fetch();
    bus.if_req = 1; bus.if_addr = 16'h0010; bus.m_rdata = 16'hABCD;
    nc(); // c1
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0010) begin bad++; $display("FAIL fetch_strobe got=%b/%h exp=1/0010", bus.m_rd, bus.m_addr); end
    total++; if (bus.if_stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_c1 got=%b exp=1", bus.if_stall); end
    nc(); // c2
    total++; if (bus.m_rd !== 1'b0 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL fetch_c2 got=%b/%b exp=0/1", bus.m_rd, bus.if_stall); end
    nc(); // c3
    total++; if (bus.if_stall !== 1'b1 || bus.if_done !== 1'b0 || bus.if_rdata !== 16'h0) begin bad++; $display("FAIL fetch_c3 got=%b/%b/%h exp=1/0/0000", bus.if_stall, bus.if_done, bus.if_rdata); end
    nc(); // c4 completion
    total++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 16'hABCD || bus.if_stall !== 1'b0) begin bad++; $display("FAIL fetch_done got=%b/%h/%b exp=1/abcd/0", bus.if_done, bus.if_rdata, bus.if_stall); end
    nc(); // c5 bubble, request still high
    total++; if (bus.m_rd !== 1'b0 || bus.if_done !== 1'b0 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL fetch_bubble got=%b/%b/%b exp=0/0/1", bus.m_rd, bus.if_done, bus.if_stall); end
    nc(); // c6 re-accept
    total++; if (bus.m_rd !== 1'b1) begin bad++; $display("FAIL fetch_reaccept got=%b exp=1", bus.m_rd); end
    bus.if_req = 0;
    nc(5);
  endtask

  task automatic test_priority();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    bus.mem_rd = 1; bus.mem_addr = 16'h0200; bus.m_rdata = 16'h5555;
    nc(); // c1
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0200) begin bad++; $display("FAIL prio_first got=%b/%h exp=1/0200", bus.m_rd, bus.m_addr); end
    total++; if (bus.mem_stall !== 1'b1 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL prio_stalls got=%b/%b exp=1/1", bus.mem_stall, bus.if_stall); end
    nc(3); // c4
    total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 16'h5555 || bus.mem_stall !== 1'b0) begin bad++; $display("FAIL prio_mem_done got=%b/%h/%b exp=1/5555/0", bus.mem_done, bus.mem_rdata, bus.mem_stall); end
    total++; if (bus.if_stall !== 1'b1 || bus.if_done !== 1'b0) begin bad++; $display("FAIL prio_if_wait got=%b/%b exp=1/0", bus.if_stall, bus.if_done); end
    bus.mem_rd = 0;
    nc(); // c5 bubble
    total++; if (bus.m_rd !== 1'b0 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL prio_bubble got=%b/%b exp=0/1", bus.m_rd, bus.if_stall); end
    nc(); // c6 IF strobe
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0010) begin bad++; $display("FAIL prio_if_strobe got=%b/%h exp=1/0010", bus.m_rd, bus.m_addr); end
    nc(2); // c8
    total++; if (bus.if_done !== 1'b0) begin bad++; $display("FAIL prio_if_early got=%b exp=0", bus.if_done); end
    bus.m_rdata = 16'hABCD;
    nc(); // c9
    total++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 16'hABCD) begin bad++; $display("FAIL prio_if_done got=%b/%h exp=1/abcd", bus.if_done, bus.if_rdata); end
    bus.if_req = 0;
    nc(3);
  endtask

  task automatic test_store();
    logic saw_rd;
    saw_rd = 0;
    bus.mem_wr = 1; bus.mem_addr = 16'h0040; bus.mem_wdata = 16'h1234; bus.m_rdata = 16'hFFFF;
    nc(); // c1
    saw_rd |= bus.m_rd;
    total++; if (bus.m_wr !== 1'b1 || bus.m_wdata !== 16'h1234 || bus.m_addr !== 16'h0040) begin bad++; $display("FAIL st_strobe got=%b/%h/%h exp=1/1234/0040", bus.m_wr, bus.m_wdata, bus.m_addr); end
    nc(); // c2
    saw_rd |= bus.m_rd;
    total++; if (bus.m_wr !== 1'b0 || bus.m_wdata !== 16'h1234) begin bad++; $display("FAIL st_pulse got=%b/%h exp=0/1234", bus.m_wr, bus.m_wdata); end
    nc(); saw_rd |= bus.m_rd;
    nc(); saw_rd |= bus.m_rd; // c4
    total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 16'h0) begin bad++; $display("FAIL st_done got=%b/%h exp=1/0000", bus.mem_done, bus.mem_rdata); end
    total++; if (saw_rd !== 1'b0) begin bad++; $display("FAIL st_no_rd got=%b exp=0", saw_rd); end
    bus.mem_wr = 0;
    nc(3);
  endtask

  task automatic test_flush();
    bus.if_req = 1; bus.if_addr = 16'h0010; bus.m_rdata = 16'h1111;
    nc(); // c1
    total++; if (bus.m_rd !== 1'b1) begin bad++; $display("FAIL fl_accept got=%b exp=1", bus.m_rd); end
    bus.if_flush = 1; bus.if_addr = 16'h0020;
    nc(); // c2 flush cycle
    total++; if (bus.if_stall !== 1'b0) begin bad++; $display("FAIL fl_stall got=%b exp=0", bus.if_stall); end
    bus.if_flush = 0;
    nc(2); // c4 completion, killed
    total++; if (bus.if_done !== 1'b0 || bus.if_rdata !== 16'h0 || bus.if_stall !== 1'b1) begin bad++; $display("FAIL fl_killed got=%b/%h/%b exp=0/0000/1", bus.if_done, bus.if_rdata, bus.if_stall); end
    nc(); // c5 bubble
    total++; if (bus.m_rd !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%b exp=0", bus.m_rd); end
    nc(); // c6
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0020) begin bad++; $display("FAIL fl_new got=%b/%h exp=1/0020", bus.m_rd, bus.m_addr); end
    nc(2);
    bus.m_rdata = 16'h2222;
    nc(); // c9
    total++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 16'h2222) begin bad++; $display("FAIL fl_new_done got=%b/%h exp=1/2222", bus.if_done, bus.if_rdata); end
    bus.if_req = 0;
    nc(3);
  endtask

  task automatic test_illegal();
    bus.mem_rd = 1; bus.mem_wr = 1; bus.mem_addr = 16'h0080; bus.m_rdata = 16'h3333;
    nc(); // c1
    total++; if (bus.err !== 1'b1 || bus.mem_done !== 1'b1 || bus.mem_rdata !== 16'h0) begin bad++; $display("FAIL ill_err got=%b/%b/%h exp=1/1/0000", bus.err, bus.mem_done, bus.mem_rdata); end
    total++; if (bus.m_rd !== 1'b0 || bus.m_wr !== 1'b0) begin bad++; $display("FAIL ill_strobe got=%b/%b exp=0/0", bus.m_rd, bus.m_wr); end
    bus.mem_wr = 0; bus.mem_addr = 16'h0090;
    nc(); // c2: err gone; legal load accepted at once, so arbiter stayed idle
    total++; if (bus.err !== 1'b0 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL ill_pulse got=%b/%b exp=0/0", bus.err, bus.mem_done); end
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0090) begin bad++; $display("FAIL ill_idle got=%b/%h exp=1/0090", bus.m_rd, bus.m_addr); end
    nc(3);
    bus.mem_rd = 0;
    nc(2);
  endtask

  task automatic test_reset_midflight();
    logic saw_done;
    saw_done = 0;
    bus.mem_rd = 1; bus.mem_addr = 16'h0300; bus.m_rdata = 16'h6666;
    nc(); // c1
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0300) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/0300", bus.m_rd, bus.m_addr); end
    nc(); // middle of second BUSY_MEM cycle
    rst_n = 0; bus.mem_rd = 0;
    #1;
    total++; if ({bus.m_rd, bus.m_wr, bus.err, bus.mem_done, bus.mem_stall, bus.if_done} !== 6'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=000000", {bus.m_rd, bus.m_wr, bus.err, bus.mem_done, bus.mem_stall, bus.if_done}); end
    total++; if ({bus.m_addr, bus.m_wdata, bus.mem_rdata} !== 48'h0) begin bad++; $display("FAIL rst_bus got=%h exp=0", {bus.m_addr, bus.m_wdata, bus.mem_rdata}); end
    nc();
    rst_n = 1;
    repeat (5) begin nc(); saw_done |= bus.mem_done | bus.m_rd; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_discard got=%b exp=0", saw_done); end
    bus.mem_rd = 1; bus.mem_addr = 16'h0400; bus.m_rdata = 16'h7777;
    nc(); // c1
    total++; if (bus.m_rd !== 1'b1 || bus.m_addr !== 16'h0400) begin bad++; $display("FAIL rst_fresh got=%b/%h exp=1/0400", bus.m_rd, bus.m_addr); end
    nc(2); // c3
    total++; if (bus.mem_done !== 1'b0) begin bad++; $display("FAIL rst_early got=%b exp=0", bus.mem_done); end
    nc(); // c4
    total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 16'h7777) begin bad++; $display("FAIL rst_fresh_done got=%b/%h exp=1/7777", bus.mem_done, bus.mem_rdata); end
    bus.mem_rd = 0;
    nc(2);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_illegal();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
